// File: rtl/axis_adjustable_sample_delay.sv
// axis_adjustable_sample_delay
//
// Streaming AXIS delay line with a run-time programmable total delay in
// samples. Total delay D splits into a whole-beat delay C = D / SAMPLE_PER_CYCLE
// (selected tap of a beat shift register) and an intra-beat delay
// R = D % SAMPLE_PER_CYCLE (samples shifted across two adjacent beats).
// Base latency is two cycles (capture stage + registered output stage).
//
// Build option:
//   AXIS_DELAY_UPDATE_ON_IDLE_EN - when defined, a latched delay request is held
//   until the input, the capture stage and the whole delay line are idle, so a
//   change never duplicates or drops samples inside a frame. When undefined, a
//   request is applied the cycle after delay_update.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   delay_samples   - requested total delay D in samples
//   delay_update    - one-cycle pulse that latches delay_samples
//   s_axis_*        - input stream (sample 0 in LSBs, earliest), no backpressure
//   m_axis_*        - delayed output stream
//   delay_active    - delay currently applied
//   delay_error     - last request exceeded the supported range (saturated)
//   delay_pending   - request latched but not yet applied

module axis_adjustable_sample_delay #(
    parameter int unsigned SAMPLE_WIDTH     = 16,
    parameter int unsigned SAMPLE_PER_CYCLE = 16,
    parameter int unsigned DATA_WIDTH       = SAMPLE_WIDTH * SAMPLE_PER_CYCLE,
    parameter int unsigned MAX_CYCLE_DELAY  = 16,
    parameter int unsigned DELAY_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DELAY_WIDTH-1:0] delay_samples,
    input  logic                   delay_update,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic [DELAY_WIDTH-1:0] delay_active,
    output logic                   delay_error,
    output logic                   delay_pending
);

    localparam int unsigned RW       = $clog2(SAMPLE_PER_CYCLE);
    localparam int unsigned DEPTH    = MAX_CYCLE_DELAY + 2;
    localparam int unsigned CW       = $clog2(DEPTH);
    localparam int unsigned DMAX_INT = MAX_CYCLE_DELAY * SAMPLE_PER_CYCLE + SAMPLE_PER_CYCLE - 1;
    localparam logic [DELAY_WIDTH-1:0] DMAX = DELAY_WIDTH'(DMAX_INT);

    // Delay control state
    logic [DELAY_WIDTH-1:0] req_q, req_d;
    logic [DELAY_WIDTH-1:0] active_q, active_d;
    logic                   err_q, err_d;
    logic                   pend_q, pend_d;
    logic                   apply;

    // Beat delay line; entry 0 is the capture stage
    logic [DATA_WIDTH-1:0] line_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] line_data_d [DEPTH];
    logic [DEPTH-1:0]      line_valid_q, line_valid_d;
    logic [DEPTH-1:0]      line_last_q, line_last_d;

    // Output stage
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;

    // Tap selection derived from the applied delay
    logic [CW-1:0]         c_idx, c_nxt;
    logic [RW-1:0]         r_sel;
    logic [DATA_WIDTH-1:0] cur_beat, old_beat;
    int unsigned           shamt;

`ifdef AXIS_DELAY_UPDATE_ON_IDLE_EN
    // Capture stage is line entry 0, so its valid bit is covered by the reduction.
    assign apply = pend_q & ~s_axis_tvalid & ~(|line_valid_q);
`else
    assign apply = pend_q;
`endif

    always_comb begin
        req_d    = req_q;
        err_d    = err_q;
        pend_d   = pend_q;
        active_d = active_q;
        if (apply) begin
            active_d = req_q;
            pend_d   = 1'b0;
        end
        // A fresh request overrides anything still waiting.
        if (delay_update) begin
            pend_d = 1'b1;
            if (delay_samples <= DMAX) begin
                req_d = delay_samples;
                err_d = 1'b0;
            end else begin
                req_d = DMAX;
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        line_data_d[0]  = s_axis_tvalid ? s_axis_tdata : '0;
        line_valid_d[0] = s_axis_tvalid;
        line_last_d[0]  = s_axis_tvalid & s_axis_tlast;
        for (int k = 1; k < int'(DEPTH); k++) begin
            line_data_d[k]  = line_data_q[k-1];
            line_valid_d[k] = line_valid_q[k-1];
            line_last_d[k]  = line_last_q[k-1];
        end
    end

    // Saturation keeps C <= MAX_CYCLE_DELAY, so C+1 always lands inside the line.
    assign c_idx    = active_q[RW +: CW];
    assign c_nxt    = c_idx + 1'b1;
    assign r_sel    = active_q[RW-1:0];
    assign cur_beat = line_data_q[c_idx];
    assign old_beat = line_data_q[c_nxt];
    assign shamt    = (SAMPLE_PER_CYCLE - 32'(r_sel)) * SAMPLE_WIDTH;

    always_comb begin
        // Output sample j = {cur, old} sample (SAMPLE_PER_CYCLE + j - R).
        m_data_d  = DATA_WIDTH'({cur_beat, old_beat} >> shamt);
        m_valid_d = line_valid_q[c_idx] | ((r_sel != '0) & line_valid_q[c_nxt]);
        m_last_d  = (r_sel == '0) ? line_last_q[c_idx] : line_last_q[c_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q        <= '0;
            active_q     <= '0;
            err_q        <= 1'b0;
            pend_q       <= 1'b0;
            line_valid_q <= '0;
            line_last_q  <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                line_data_q[k] <= '0;
            end
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            req_q        <= req_d;
            active_q     <= active_d;
            err_q        <= err_d;
            pend_q       <= pend_d;
            line_valid_q <= line_valid_d;
            line_last_q  <= line_last_d;
            for (int k = 0; k < int'(DEPTH); k++) begin
                line_data_q[k] <= line_data_d[k];
            end
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign delay_active  = active_q;
    assign delay_error   = err_q;
    assign delay_pending = pend_q;

endmodule

// File: tb/tb_axis_adjustable_sample_delay.sv
// Testbench for axis_adjustable_sample_delay: the input is viewed as one long
// sample stream (invalid beats contribute zeros); each output beat is the
// stream shifted by D samples, checked by a scoreboard with arrival times.

module tb_axis_adjustable_sample_delay;

    localparam int SW    = 16;
    localparam int SPC   = 16;
    localparam int DW    = SW * SPC;
    localparam int MAXC  = 16;
    localparam int DLW   = 16;
    localparam int DMAX  = MAXC * SPC + SPC - 1;
    localparam int NCYC  = 4000;
    localparam int DRAIN = MAXC + 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [DLW-1:0] delay_samples;
    logic           delay_update;
    logic [DW-1:0]  s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic [DW-1:0]  m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic [DLW-1:0] delay_active;
    logic           delay_error;
    logic           delay_pending;

    axis_adjustable_sample_delay #(
        .SAMPLE_WIDTH    (SW),
        .SAMPLE_PER_CYCLE(SPC),
        .DATA_WIDTH      (DW),
        .MAX_CYCLE_DELAY (MAXC),
        .DELAY_WIDTH     (DLW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .delay_samples(delay_samples),
        .delay_update (delay_update),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .delay_active (delay_active),
        .delay_error  (delay_error),
        .delay_pending(delay_pending)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            t;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    // Input history, indexed by stimulus cycle and by absolute sample index
    logic           hist_v [NCYC];
    logic           hist_l [NCYC];
    logic [SW-1:0]  hist_s [NCYC*SPC];
    int             cyc     = 100;
    int             base    = 100;
    int             model_d = 0;

    function automatic int sat(input int d);
        return (d > DMAX) ? DMAX : d;
    endfunction

    function automatic void chk(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    // Output beat for stimulus cycle m = input stream delayed by d samples.
    function automatic void model(input int m, input int d, output logic [DW-1:0] data,
                                  output logic v, output logic l);
        int k;
        int b;
        data = '0;
        v    = 1'b0;
        for (int j = 0; j < SPC; j++) begin
            k = m * SPC + j - d;
            b = k / SPC;
            if (b >= base && hist_v[b]) begin
                data[j*SW +: SW] = hist_s[k];
                v = 1'b1;
            end
        end
        b = (m * SPC - d) / SPC;
        l = (b >= base) ? hist_l[b] : 1'b0;
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] data, input bit l,
                        input bit upd, input int d, input bit do_rst);
        logic [DW-1:0] ed;
        logic          ev;
        logic          el;
        rst           = do_rst;
        s_axis_tvalid = v;
        s_axis_tdata  = data;
        s_axis_tlast  = l;
        delay_update  = upd;
        delay_samples = DLW'(d);
        hist_v[cyc] = v & !do_rst;
        hist_l[cyc] = v & l & !do_rst;
        for (int j = 0; j < SPC; j++) begin
            hist_s[cyc*SPC + j] = (v && !do_rst) ? data[j*SW +: SW] : '0;
        end
        if (!do_rst) begin
            model(cyc, model_d, ed, ev, el);
            if (ev) exp_q.push_back('{data: ed, last: el, t: edge_cnt + 2});
            if (upd) model_d = sat(d);
        end
        @(posedge clk);
        #1;
        if (do_rst) begin
            exp_q.delete();
            base    = cyc + 1;
            model_d = 0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic drain_check(input string name);
        idle(DRAIN);
        chk(name, DW'(exp_q.size()), DW'(0));
        exp_q.delete();
    endtask

    task automatic set_delay(input int d);
        idle(DRAIN);
        step(1'b0, '0, 1'b0, 1'b1, d, 1'b0);
        chk("pending_pulse", DW'(delay_pending), DW'(1));
        chk("delay_error", DW'(delay_error), DW'(d > DMAX));
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b0);
        chk("delay_active", DW'(delay_active), DW'(sat(d)));
        chk("pending_clear", DW'(delay_pending), DW'(0));
    endtask

    function automatic logic [DW-1:0] counter_beat(input int k);
        logic [DW-1:0] b;
        for (int j = 0; j < SPC; j++) b[j*SW +: SW] = SW'(SPC * k + j);
        return b;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] b;
        for (int w = 0; w < DW / 32; w++) b[w*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic counter_frame(input int n);
        for (int k = 0; k < n; k++) step(1'b1, counter_beat(k), k == n - 1, 1'b0, 0, 1'b0);
    endtask

    // Random frame with random idle gaps between beats
    task automatic rand_frame(input int n);
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(0, 3) == 0) idle(1);
            step(1'b1, rand_beat(), k == n - 1, 1'b0, 0, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && m_axis_tvalid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got data %h last %b at edge %0d, expected none",
                         m_axis_tdata, m_axis_tlast, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || edge_cnt != e.t) begin
                    n_fail++;
                    $display("FAIL out_beat: got %h last %b edge %0d; expected %h last %b edge %0d",
                             m_axis_tdata, m_axis_tlast, edge_cnt, e.data, e.last, e.t);
                end
            end
        end
    end

    initial begin
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 40, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b0);
        chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_tlast", DW'(m_axis_tlast), DW'(0));
        chk("rst_active", DW'(delay_active), DW'(0));
        chk("rst_error", DW'(delay_error), DW'(0));
        chk("rst_pending", DW'(delay_pending), DW'(0));
        mon_en = 1'b1;

        // Zero delay, intra-only, mixed
        set_delay(0);
        counter_frame(4);
        drain_check("drain_d0");
        set_delay(5);
        counter_frame(4);
        drain_check("drain_d5");
        set_delay(35);
        counter_frame(4);
        drain_check("drain_d35");

        // Saturation then back in range
        set_delay(400);
        counter_frame(3);
        drain_check("drain_sat");
        set_delay(16);
        counter_frame(3);
        drain_check("drain_d16");

        // Gap between frames with D=5
        set_delay(5);
        counter_frame(3);
        idle(3);
        counter_frame(3);
        drain_check("drain_gap");

        // Reset mid-frame
        set_delay(21);
        step(1'b1, rand_beat(), 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, rand_beat(), 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, rand_beat(), 1'b0, 1'b0, 0, 1'b1);
        chk("midrst_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("midrst_tdata", m_axis_tdata, '0);
        chk("midrst_active", DW'(delay_active), DW'(0));
        drain_check("drain_after_rst");
        counter_frame(2);
        drain_check("drain_post_rst");

        // Randomized delays and frames, including out-of-range requests
        for (int it = 0; it < 10; it++) begin
            set_delay($urandom_range(0, 320));
            rand_frame($urandom_range(1, 6));
            rand_frame($urandom_range(1, 6));
            drain_check("drain_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_adjustable_sample_delay.md
Name: axis_adjustable_sample_delay

Overview:
- Streaming AXIS delay line that shifts a multi-sample-per-cycle stream by a run-time programmable total delay in samples.
- Total delay = whole-cycle delay (beat delay line) + intra-cycle delay (sample shift across two adjacent beats).
- Sits in the DAC/ADC datapath to align photonic channels before modulation/readback.
- Successor to the fixed two-beat intra-cycle shifter: adds parametrised sample width, cycle-delay depth, saturation and update handshake.

Parameters:
SAMPLE_WIDTH, 16, bits per sample
SAMPLE_PER_CYCLE, 16, samples per beat; power of two, >=2
DATA_WIDTH, SAMPLE_WIDTH*SAMPLE_PER_CYCLE, tdata width
MAX_CYCLE_DELAY, 16, max whole-cycle delay C
DELAY_WIDTH, 16, width of delay request

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
delay_samples  in  DELAY_WIDTH  requested total delay D, in samples
delay_update  in  1  one-cycle pulse; latch delay_samples
s_axis_tdata  in  DATA_WIDTH  input samples; sample 0 in LSBs, earliest in time
s_axis_tvalid  in  1  input valid; no backpressure
s_axis_tlast  in  1  input frame end
m_axis_tdata  out  DATA_WIDTH  delayed samples
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  output frame end
delay_active  out  DELAY_WIDTH  delay currently applied
delay_error  out  1  sticky: last request exceeded range
delay_pending  out  1  request latched, not yet applied

Behaviour:
- Clocking: single clock domain, clk. Reset is synchronous and active-high (rst).
- Reset: all outputs 0; active C=R=0; delay line valid/last/data cleared. Reset mid-frame drops all in-flight beats; no output until new input.
- DMAX = MAX_CYCLE_DELAY*SAMPLE_PER_CYCLE + SAMPLE_PER_CYCLE-1.
- On delay_update: if D<=DMAX, request=D and delay_error<=0. Else request=DMAX and delay_error<=1. delay_error holds until the next update.
- C = request / SAMPLE_PER_CYCLE and R = request % SAMPLE_PER_CYCLE, taken by bit slicing.
- Capture stage (1 cycle): if s_axis_tvalid, register data/last with valid=1. Otherwise register data=0, valid=0, last=0.
- Delay line: shift register of MAX_CYCLE_DELAY+2 captured beats. Tap k = beat captured k cycles earlier.
- Output stage (registered), cur = tap C, old = tap C+1:
  - output sample j = cur sample j-R for j>=R; old sample SAMPLE_PER_CYCLE+j-R for j<R.
  - m_axis_tvalid = valid[C] | (R!=0 & valid[C+1]).
  - m_axis_tlast = (R==0) ? last[C] : last[C+1].
- Latency: input beat n, sample j appears at output beat n+C (+1 if j+R>=SAMPLE_PER_CYCLE), 2 cycles base latency. With D=0 the module is a 2-cycle pipe, bit-exact.
- Invalid gaps contribute zero samples. A frame with R!=0 emits one extra trailing beat carrying the tail and tlast.
- Apply rule: pending request applied the cycle after delay_update. delay_active updates the same cycle; delay_pending is a 1-cycle pulse.
- An update coinciding with rst is ignored.
- A mid-stream change may duplicate or drop samples; this is not protected against (see optional feature).
- Back-to-back frames: tlast of frame A and first valid of frame B may share an output beat when R!=0. Sample packing is continuous; no re-framing.

Optional Feature:
- Macro: AXIS_DELAY_UPDATE_ON_IDLE_EN.
- Defined: latched request is held while delay_pending=1. It is applied only on a cycle where s_axis_tvalid=0, all delay-line valid bits are 0, and the capture stage is invalid. This guarantees no sample duplication or loss mid-frame. A new delay_update while pending overwrites the request.
- Undefined: request applied the cycle after delay_update, as above.

Test Plan:
- Zero delay: D=0, 4-beat frame, sample(k,j)=16k+j -> output identical 2 cycles later, tlast on beat 3, tvalid 4 cycles.
- Intra only: D=5 -> first output beat samples 0..4 =0, 5..15 =0..10. Next beat = 11..26. Five beats out, tlast on 5th; 5th beat samples 0..4 =59..63, rest 0.
- Mixed: D=35 (C=2,R=3) -> first nonzero output 2 cycles after the D=0 case. Sample 3 of that beat = 0; beat sequence otherwise as the R=3 shift.
- Saturation: D=400 with defaults (DMAX=271) -> delay_active=271, delay_error=1. Then D=16 -> delay_active=16, delay_error=0, pure 1-beat delay.
- Gap/reset: frame, 3 idle cycles, frame with D=5 -> zeros fill the gap. Assert rst mid-frame -> outputs 0 next cycle, no residual beats after release.
- Macro on: update D=3 mid-frame -> delay_pending=1 until the delay line drains; first frame unshifted; next frame shifted by 3.
